// File: rtl/reg_file_pkg.sv
// Shared types and default sizing for the parametrised register file.
package reg_file_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } rf_state_t;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_NUM_REGS = 4;

endpackage

// File: rtl/rf_clear_seq.sv
// Sequential clear engine: walks a pointer over every register address,
// one per cycle, so architectural state can be flushed without a reset.
module rf_clear_seq
    import reg_file_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear_req,
    output logic          busy,
    output logic          sweep_en,
    output logic [AW-1:0] sweep_addr
);

    rf_state_t     state;
    logic [AW-1:0] ptr;

    // A request seen while sweeping is dropped, not queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear_req) begin
                        state <= SWEEP;
                        ptr   <= '0;
                    end
                end
                SWEEP: begin
                    if (ptr == AW'(NUM_REGS - 1)) begin
                        state <= IDLE;
                        ptr   <= '0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    ptr   <= '0;
                end
            endcase
        end
    end

    assign busy       = (state == SWEEP);
    assign sweep_en   = (state == SWEEP);
    assign sweep_addr = ptr;

endmodule

// File: rtl/reg_file_param.sv
// Parametrised 2-read/1-write register file with valid bits, optional zero
// register, optional write-to-read bypass and a sequential clear sweep.
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int AW       = $clog2(NUM_REGS),
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             WriteEn,
    input  logic [AW-1:0]    Waddr,
    input  logic [WIDTH-1:0] DataIn,
    input  logic [AW-1:0]    RaddrA,
    input  logic [AW-1:0]    RaddrB,
    output logic [WIDTH-1:0] DataOutA,
    output logic [WIDTH-1:0] DataOutB,
    output logic             ValidA,
    output logic             ValidB,
    input  logic             ClearReq,
    output logic             Busy
);

    logic [WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0] vld;
    logic             busy;
    logic             sweep_en;
    logic [AW-1:0]    sweep_addr;
    logic             wr_acc;

    rf_clear_seq #(
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_clear_seq (
        .clk        (Clk),
        .rst_n      (Reset),
        .clear_req  (ClearReq),
        .busy       (busy),
        .sweep_en   (sweep_en),
        .sweep_addr (sweep_addr)
    );

    assign Busy   = busy;
    assign wr_acc = WriteEn && !busy && !((ZERO_REG != 0) && (Waddr == '0));

    // wr_acc already excludes the sweep, so the two branches never collide.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            vld <= '0;
        end else if (sweep_en) begin
            regs[sweep_addr] <= '0;
            vld[sweep_addr]  <= 1'b0;
        end else if (wr_acc) begin
            regs[Waddr] <= DataIn;
            vld[Waddr]  <= 1'b1;
        end
    end

    logic [AW-1:0]    raddr [2];
    logic [WIDTH-1:0] rdata [2];
    logic             rvld  [2];

    assign raddr[0] = RaddrA;
    assign raddr[1] = RaddrB;

    // Zero register takes priority over the bypass path.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata[p] = regs[raddr[p]];
            rvld[p]  = vld[raddr[p]];
            if ((BYPASS != 0) && wr_acc && (raddr[p] == Waddr)) begin
                rdata[p] = DataIn;
                rvld[p]  = 1'b1;
            end
            if ((ZERO_REG != 0) && (raddr[p] == '0)) begin
                rdata[p] = '0;
                rvld[p]  = 1'b1;
            end
        end
    end

    assign DataOutA = rdata[0];
    assign DataOutB = rdata[1];
    assign ValidA   = rvld[0];
    assign ValidB   = rvld[1];

endmodule

// File: tb/tb_reg_file_param.sv
// Drives three configurations (bypass, no bypass, zero register) with shared
// stimulus and compares each against a behavioural scoreboard model.
module tb_reg_file_param;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int AW = 2;
    localparam int NC = 3;  // 0: BYPASS=1, 1: BYPASS=0, 2: ZERO_REG=1 + BYPASS=1

    typedef struct packed {
        logic [W-1:0] da;
        logic [W-1:0] db;
        logic         va;
        logic         vb;
        logic         busy;
    } out_t;
    typedef out_t [NC-1:0] vec_t;

    logic          Clk = 1'b0;
    logic          Reset = 1'b0;
    logic          WriteEn = 1'b0;
    logic          ClearReq = 1'b0;
    logic [AW-1:0] Waddr = '0;
    logic [AW-1:0] RaddrA = '0;
    logic [AW-1:0] RaddrB = '0;
    logic [W-1:0]  DataIn = '0;

    logic [W-1:0] doa [NC];
    logic [W-1:0] dob [NC];
    logic         va  [NC];
    logic         vb  [NC];
    logic         bsy [NC];
    vec_t         obs;

    always #5 Clk = ~Clk;

    for (genvar c = 0; c < NC; c++) begin : g_dut
        reg_file_param #(
            .WIDTH    (W),
            .NUM_REGS (N),
            .ZERO_REG ((c == 2) ? 1 : 0),
            .BYPASS   ((c == 1) ? 0 : 1)
        ) u_dut (
            .Clk      (Clk),
            .Reset    (Reset),
            .WriteEn  (WriteEn),
            .Waddr    (Waddr),
            .DataIn   (DataIn),
            .RaddrA   (RaddrA),
            .RaddrB   (RaddrB),
            .DataOutA (doa[c]),
            .DataOutB (dob[c]),
            .ValidA   (va[c]),
            .ValidB   (vb[c]),
            .ClearReq (ClearReq),
            .Busy     (bsy[c])
        );
        assign obs[c] = {doa[c], dob[c], va[c], vb[c], bsy[c]};
    end

    // Reference model and scoreboard
    logic [W-1:0] m_reg [NC][N];
    logic         m_vld [NC][N];
    logic         m_sweep;
    int           m_ptr;
    vec_t         sb [$];
    vec_t         e;
    int           nvec = 0;
    int           nmis = 0;

    function automatic logic acc(int c);
        return WriteEn && !m_sweep && !(c == 2 && Waddr == 0);
    endfunction

    function automatic logic [W:0] rd(int c, logic [AW-1:0] ra);
        if (c == 2 && ra == 0) return {1'b1, {W{1'b0}}};
        if (c != 1 && acc(c) && ra == Waddr) return {1'b1, DataIn};
        return {m_vld[c][ra], m_reg[c][ra]};
    endfunction

    function automatic out_t predict(int c);
        out_t o;
        logic [W:0] a, b;
        a = rd(c, RaddrA);
        b = rd(c, RaddrB);
        o.da = a[W-1:0];
        o.va = a[W];
        o.db = b[W-1:0];
        o.vb = b[W];
        o.busy = m_sweep;
        return o;
    endfunction

    task automatic m_reset();
        for (int c = 0; c < NC; c++)
            for (int r = 0; r < N; r++) begin
                m_reg[c][r] = '0;
                m_vld[c][r] = 1'b0;
            end
        m_sweep = 1'b0;
        m_ptr   = 0;
    endtask

    task automatic m_clock();
        for (int c = 0; c < NC; c++) begin
            if (m_sweep) begin
                m_reg[c][m_ptr] = '0;
                m_vld[c][m_ptr] = 1'b0;
            end else if (acc(c)) begin
                m_reg[c][Waddr] = DataIn;
                m_vld[c][Waddr] = 1'b1;
            end
        end
        if (!m_sweep) begin
            if (ClearReq) begin
                m_sweep = 1'b1;
                m_ptr   = 0;
            end
        end else if (m_ptr == N - 1) begin
            m_sweep = 1'b0;
            m_ptr   = 0;
        end else begin
            m_ptr++;
        end
    endtask

    task automatic push_expected();
        vec_t x;
        for (int c = 0; c < NC; c++) x[c] = predict(c);
        sb.push_back(x);
    endtask

    // Called at a falling edge; samples two time units later.
    task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [W-1:0] di,
                         input logic [AW-1:0] ra, input logic [AW-1:0] rb, input logic clr);
        WriteEn = we; Waddr = wa; DataIn = di; RaddrA = ra; RaddrB = rb; ClearReq = clr;
        #2;
        push_expected();
    endtask

    task automatic tick();
        @(posedge Clk);
        if (Reset) m_clock();
        @(negedge Clk);
    endtask

    task automatic test_reset();
        for (int a = 0; a < N; a++) begin
            drive(1'b0, '0, '0, AW'(a), AW'(N - 1 - a), 1'b0);
            e = sb.pop_front(); nvec++;
            if (obs !== e) begin nmis++; $display("FAIL reset_read a=%0d: got %h want %h", a, obs, e); end
            nvec++;
            if (doa[0] !== 8'h00 || va[0] !== 1'b0 || bsy[0] !== 1'b0) begin
                nmis++; $display("FAIL reset_const a=%0d: got %h/%b/%b want 00/0/0", a, doa[0], va[0], bsy[0]);
            end
            tick();
        end
        Reset = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        drive(1'b1, 2'd2, 8'hA5, 2'd2, 2'd0, 1'b0);
        e = sb.pop_front(); nvec++;
        if (obs !== e) begin nmis++; $display("FAIL write_r2: got %h want %h", obs, e); end
        tick();
        drive(1'b0, '0, '0, 2'd2, 2'd2, 1'b0);
        e = sb.pop_front(); nvec++;
        if (obs !== e) begin nmis++; $display("FAIL read_r2: got %h want %h", obs, e); end
        nvec++;
        if (doa[1] !== 8'hA5 || va[1] !== 1'b1) begin
            nmis++; $display("FAIL read_r2_const: got %h/%b want a5/1", doa[1], va[1]);
        end
        tick();
    endtask

    task automatic test_bypass();
        drive(1'b1, 2'd1, 8'h3C, 2'd1, 2'd1, 1'b0);
        e = sb.pop_front(); nvec++;
        if (obs !== e) begin nmis++; $display("FAIL bypass_same_cycle: got %h want %h", obs, e); end
        nvec++;
        if (doa[0] !== 8'h3C || va[0] !== 1'b1 || doa[1] !== 8'h00 || va[1] !== 1'b0) begin
            nmis++; $display("FAIL bypass_const: got %h/%b %h/%b want 3c/1 00/0", doa[0], va[0], doa[1], va[1]);
        end
        tick();
        drive(1'b0, '0, '0, 2'd1, 2'd2, 1'b0);
        e = sb.pop_front(); nvec++;
        if (obs !== e) begin nmis++; $display("FAIL bypass_after_edge: got %h want %h", obs, e); end
        nvec++;
        if (doa[1] !== 8'h3C) begin nmis++; $display("FAIL nobypass_after_edge: got %h want 3c", doa[1]); end
        tick();
    endtask

    task automatic test_clear_sweep();
        logic [W-1:0] vals [N];
        int busy_cycles;
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        for (int r = 0; r < N; r++) begin
            drive(1'b1, AW'(r), vals[r], AW'(r), '0, 1'b0);
            e = sb.pop_front(); nvec++;
            if (obs !== e) begin nmis++; $display("FAIL load r%0d: got %h want %h", r, obs, e); end
            tick();
        end
        drive(1'b0, '0, '0, '0, '0, 1'b1);
        e = sb.pop_front(); nvec++;
        if (obs !== e) begin nmis++; $display("FAIL clear_pulse: got %h want %h", obs, e); end
        tick();
        busy_cycles = 0;
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, '0, '0, AW'(k), AW'(k - 1), 1'b0);
            e = sb.pop_front(); nvec++;
            if (obs !== e) begin nmis++; $display("FAIL sweep k=%0d: got %h want %h", k, obs, e); end
            if (bsy[0]) busy_cycles++;
            tick();
        end
        nvec++;
        if (busy_cycles !== 4) begin nmis++; $display("FAIL sweep_len: got %0d want 4", busy_cycles); end
    endtask

    task automatic test_sweep_collision();
        int busy_cycles;
        drive(1'b1, 2'd3, 8'h99, 2'd3, 2'd3, 1'b0);
        e = sb.pop_front(); nvec++;
        if (obs !== e) begin nmis++; $display("FAIL coll_load: got %h want %h", obs, e); end
        tick();
        drive(1'b0, '0, '0, 2'd3, 2'd3, 1'b1);
        e = sb.pop_front(); nvec++;
        if (obs !== e) begin nmis++; $display("FAIL coll_clear: got %h want %h", obs, e); end
        tick();
        busy_cycles = 0;
        for (int k = 0; k < 8; k++) begin
            drive(k == 0, 2'd3, 8'hFF, 2'd3, AW'(k), k == 1);
            e = sb.pop_front(); nvec++;
            if (obs !== e) begin nmis++; $display("FAIL coll k=%0d: got %h want %h", k, obs, e); end
            if (bsy[0]) busy_cycles++;
            tick();
        end
        nvec++;
        if (busy_cycles !== 4) begin nmis++; $display("FAIL coll_sweep_len: got %0d want 4", busy_cycles); end
        drive(1'b0, '0, '0, 2'd3, 2'd3, 1'b0);
        e = sb.pop_front(); nvec++;
        if (obs !== e) begin nmis++; $display("FAIL coll_r3: got %h want %h", obs, e); end
        nvec++;
        if (doa[0] !== 8'h00 || va[0] !== 1'b0) begin
            nmis++; $display("FAIL coll_r3_const: got %h/%b want 00/0", doa[0], va[0]);
        end
        tick();
    endtask

    task automatic test_zero_reg();
        drive(1'b1, 2'd0, 8'h77, 2'd0, 2'd0, 1'b0);
        e = sb.pop_front(); nvec++;
        if (obs !== e) begin nmis++; $display("FAIL zero_write: got %h want %h", obs, e); end
        nvec++;
        if (doa[2] !== 8'h00 || va[2] !== 1'b1) begin
            nmis++; $display("FAIL zero_const: got %h/%b want 00/1", doa[2], va[2]);
        end
        tick();
        drive(1'b1, 2'd1, 8'h55, 2'd1, 2'd0, 1'b1);
        e = sb.pop_front(); nvec++;
        if (obs !== e) begin nmis++; $display("FAIL zero_wr_clr: got %h want %h", obs, e); end
        tick();
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, '0, '0, 2'd1, 2'd0, 1'b0);
            e = sb.pop_front(); nvec++;
            if (obs !== e) begin nmis++; $display("FAIL zero_sweep k=%0d: got %h want %h", k, obs, e); end
            if (k == 0) begin
                nvec++;
                if (doa[2] !== 8'h55) begin nmis++; $display("FAIL zero_r1_held: got %h want 55", doa[2]); end
            end
            tick();
        end
        nvec++;
        if (doa[2] !== 8'h00 || va[2] !== 1'b0) begin
            nmis++; $display("FAIL zero_r1_cleared: got %h/%b want 00/0", doa[2], va[2]);
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 2'd2, 8'h5A, 2'd2, 2'd3, 1'b0);
        e = sb.pop_front(); nvec++;
        if (obs !== e) begin nmis++; $display("FAIL ar_load: got %h want %h", obs, e); end
        tick();
        drive(1'b0, '0, '0, 2'd2, 2'd3, 1'b1);
        e = sb.pop_front(); nvec++;
        if (obs !== e) begin nmis++; $display("FAIL ar_clear: got %h want %h", obs, e); end
        tick();
        tick();
        drive(1'b0, '0, '0, 2'd2, 2'd3, 1'b0);
        e = sb.pop_front(); nvec++;
        if (obs !== e) begin nmis++; $display("FAIL ar_mid_sweep: got %h want %h", obs, e); end
        #1 Reset = 1'b0;
        #1;
        m_reset();
        push_expected();
        e = sb.pop_front(); nvec++;
        if (obs !== e) begin nmis++; $display("FAIL ar_async: got %h want %h", obs, e); end
        nvec++;
        if (bsy[0] !== 1'b0 || doa[0] !== 8'h00 || va[0] !== 1'b0 || va[2] !== 1'b0) begin
            nmis++; $display("FAIL ar_async_const: got busy=%b da=%h va=%b want 0/00/0", bsy[0], doa[0], va[0]);
        end
        tick();
        Reset = 1'b1;
        tick();
        drive(1'b0, '0, '0, 2'd2, 2'd0, 1'b0);
        e = sb.pop_front(); nvec++;
        if (obs !== e) begin nmis++; $display("FAIL ar_after: got %h want %h", obs, e); end
        tick();
    endtask

    initial begin
        m_reset();
        @(negedge Clk);
        test_reset();
        test_write_read();
        test_bypass();
        test_clear_sweep();
        test_sweep_collision();
        test_zero_reg();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
